// File: rtl/sound_arbiter.sv
// Round-robin arbiter that lets several requesters share one sound_controller.
// A granted code is played for TONE_CYCLES clocks, then GAP_CYCLES clocks of forced mute follow.
module sound_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TONE_CYCLES = 1200000,
  parameter int GAP_CYCLES  = 120000,
  parameter int CNT_W       = 24
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [N_REQ-1:0]   req,
  input  logic [2*N_REQ-1:0] req_code,
  output logic [1:0]         code_sound,
  output logic               mute,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic [N_REQ-1:0]   pending
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    GAP  = 2'b10
  } state_t;

  state_t             state_r;
  logic [N_REQ-1:0]   pending_r;
  logic [1:0]         codes_r [N_REQ];
  logic [IDX_W-1:0]   last_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [1:0]         code_sound_r;
  logic               mute_r;
  logic [N_REQ-1:0]   grant_r;
  logic               busy_r;

  logic [IDX_W-1:0]   win_s;
  logic               win_valid_s;
  logic [N_REQ-1:0]   pend_next_s;

  // Pick the first pending requester after the last winner, wrapping around.
  always_comb begin
    win_s       = '0;
    win_valid_s = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      logic [IDX_W-1:0] idx_v;
      idx_v = IDX_W'((int'(last_r) + k) % N_REQ);
      if (!win_valid_s && pending_r[idx_v]) begin
        win_valid_s = 1'b1;
        win_s       = idx_v;
      end else begin
        win_valid_s = win_valid_s;
      end
    end
  end

  // Next pending set: the grant clears the winner, but a new pulse in the same cycle re-queues it.
  always_comb begin
    pend_next_s = pending_r;
    if (state_r == IDLE && win_valid_s) begin
      pend_next_s[win_s] = 1'b0;
    end else begin
      pend_next_s = pending_r;
    end
    pend_next_s = pend_next_s | req;
  end

  // Request latch, arbitration FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r      <= IDLE;
      pending_r    <= '0;
      for (int i = 0; i < N_REQ; i++) codes_r[i] <= 2'b00;
      last_r       <= IDX_W'(N_REQ - 1);
      cnt_r        <= '0;
      code_sound_r <= 2'b00;
      mute_r       <= 1'b1;
      grant_r      <= '0;
      busy_r       <= 1'b0;
    end else begin
      pending_r <= pend_next_s;
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i]) codes_r[i] <= req_code[2*i +: 2];
      end
      grant_r <= '0;
      case (state_r)
        IDLE: begin
          if (win_valid_s) begin
            state_r      <= PLAY;
            code_sound_r <= codes_r[win_s];
            mute_r       <= 1'b0;
            grant_r      <= N_REQ'(1'b1) << win_s;
            busy_r       <= 1'b1;
            last_r       <= win_s;
            cnt_r        <= CNT_W'(TONE_CYCLES - 1);
          end else begin
            mute_r <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        PLAY: begin
          if (cnt_r == '0) begin
            mute_r       <= 1'b1;
            code_sound_r <= 2'b00;
            if (GAP_CYCLES > 0) begin
              state_r <= GAP;
              cnt_r   <= CNT_W'(GAP_CYCLES - 1);
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1'b1);
          end
        end
        GAP: begin
          if (cnt_r == '0) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1'b1);
          end
        end
        default: begin
          state_r      <= IDLE;
          mute_r       <= 1'b1;
          busy_r       <= 1'b0;
          code_sound_r <= 2'b00;
          cnt_r        <= '0;
        end
      endcase
    end
  end

  assign code_sound = code_sound_r;
  assign mute       = mute_r;
  assign grant      = grant_r;
  assign busy       = busy_r;
  assign pending    = pending_r;

endmodule

// File: doc/sound_arbiter.md
Name: sound_arbiter

Overview:
- Shares the single sound_controller between several sound requesters: the numbers engine, future collision and score logic, and the velocity buttons.
- Latches one-cycle request pulses and picks a winner by round-robin.
- Drives code_sound/mute for a fixed tone duration, followed by a silent gap.
- Sits between the requesters and sound_controller in top, on the system clock.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TONE_CYCLES, 1200000, clocks a granted tone is played (100 ms at 12 MHz); must be >= 1.
- GAP_CYCLES, 120000, clocks of forced mute between tones; 0 means no gap.
- CNT_W, 24, width of the duration counter; must hold max(TONE_CYCLES, GAP_CYCLES) - 1.

Ports:
- clk  input  1  system clock (12 MHz).
- clr  input  1  reset; synchronous, active-high.
- req  input  N_REQ  one-cycle request pulse per requester.
- req_code  input  2*N_REQ  sound code per requester; bits [2i+1:2i] belong to req[i], sampled with req[i].
- code_sound  output  2  code to sound_controller.
- mute  output  1  1 = silence, to sound_controller.
- grant  output  N_REQ  one-hot, one-cycle pulse in the first PLAY cycle of the winner.
- busy  output  1  1 in PLAY or GAP.
- pending  output  N_REQ  latched-but-unserved request bits (debug).

Behaviour:
- Reset state: when clr is sampled high, on that edge:
  - state=IDLE; pending=0; stored codes=0.
  - code_sound=2'b00; mute=1; grant=0; busy=0; counter=0.
  - Round-robin pointer last=N_REQ-1, so requester 0 has first priority.
  - clr overrides every other event in the same cycle, including mid-tone; the tone stops on that edge.
- Request latch: req[i]=1 at an edge sets pending[i] and stores req_code[i].
  - A repeat req[i] while pending[i]=1 overwrites the stored code; no second entry is created.
- All outputs are registered.
- IDLE:
  - mute=1, busy=0.
  - If pending != 0, select the winner w: the first set bit scanning last+1, last+2, ... modulo N_REQ.
  - At the edge: state=PLAY, code_sound=code[w], mute=0, grant[w]=1, busy=1, pending[w]=0, last=w, counter=TONE_CYCLES-1.
  - Only bits already registered in pending are considered; a req arriving in the same cycle competes next time.
- PLAY:
  - grant returns to 0 after the first cycle.
  - Counter decrements each clock; mute=0 for exactly TONE_CYCLES clocks.
  - At counter=0, one of:
    - If GAP_CYCLES>0: go to GAP, mute=1, code_sound=0, counter=GAP_CYCLES-1.
    - Else: go to IDLE with mute=1.
- GAP:
  - mute=1 and busy=1 for exactly GAP_CYCLES clocks.
  - At counter=0, go to IDLE with busy=0.
- Latency: req[i] pulse sampled at edge E with the arbiter idle and nothing else pending:
  - pending[i]=1 after E; grant/mute=0 after E+1 (2 clocks).
  - Back-to-back service: the next tone's first PLAY edge is 1 clock after the end of GAP (one IDLE cycle).
- Simultaneous events:
  - req[i] in the same cycle pending[i] is cleared by grant: set wins. pending[i] stays 1 with the new code, and the requester is queued again.
  - Requests from the currently playing requester are accepted and queued.
- Round-robin fairness: with all requesters continuously pending, grants cycle 0,1,2,...,N_REQ-1,0,...
- No starvation: a pending requester is granted within N_REQ tones.

Test Plan:
- Reset and single request (N_REQ=4, TONE_CYCLES=8, GAP_CYCLES=2):
  - clr 3 cycles, then check mute=1, code_sound=0, busy=0, pending=0.
  - req[2] pulse with code 2'b10 at edge 10: grant=4'b0100 and mute=0 after edge 11; code_sound=2'b10 for 8 clocks; mute=1 for 2 clocks; busy=0 after edge 21.
- Round-robin: req=4'b1111 in one cycle with codes 0,1,2,3 -> grants in order 0,1,2,3, each tone 8 clocks, gaps of 2 clocks, 11 clocks per grant period. Then req=4'b0101 -> grant 0 then 2.
- Code overwrite and set-wins:
  - req[1] code 01, then req[1] code 11 while pending -> plays 11 once.
  - req[3] asserted on its own grant edge -> pending[3]=1 afterwards and a second tone follows.
- Reset mid-tone: clr during PLAY clock 4 -> mute=1, code_sound=0, busy=0, pending=0 on the next edge; no further grants without new req.
- GAP_CYCLES=0 build: two pending requests -> mute=0 for 8 clocks, mute=1 for exactly 1 clock (IDLE), then mute=0 for the second tone.
